// File: rtl/alu_seq_pkg.sv
`default_nettype none
//==============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the sequential ALU: the 4-bit CTL
//               operation codes (same encoding as the legacy combinational
//               ALU), the control FSM state type and a helper that classifies
//               iterative operations.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
package alu_seq_pkg;

    localparam logic [3:0] c_ctl_and   = 4'b0000;
    localparam logic [3:0] c_ctl_or    = 4'b0001;
    localparam logic [3:0] c_ctl_add   = 4'b0010;
    localparam logic [3:0] c_ctl_xor   = 4'b0011;
    localparam logic [3:0] c_ctl_sll   = 4'b0100;
    localparam logic [3:0] c_ctl_srl   = 4'b0101;
    localparam logic [3:0] c_ctl_sub   = 4'b0110;
    localparam logic [3:0] c_ctl_slt   = 4'b0111;
    localparam logic [3:0] c_ctl_mul   = 4'b1000;
    localparam logic [3:0] c_ctl_mulhu = 4'b1001;
    localparam logic [3:0] c_ctl_divu  = 4'b1010;
    localparam logic [3:0] c_ctl_remu  = 4'b1011;
    localparam logic [3:0] c_ctl_nor   = 4'b1100;
    localparam logic [3:0] c_ctl_sra   = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Codes 1000..1011 run on the multi-cycle engine; the low two bits then
    // select MUL / MULHU / DIVU / REMU inside the engine.
    function automatic logic is_iterative(input logic [3:0] ctl);
        return (ctl[3:2] == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
//==============================================================================
// Module      : alu_muldiv
// Description : Iterative unsigned multiply / divide engine. One shift-add
//               (multiply) or restoring shift-subtract (divide) step per cycle,
//               WORDSIZE steps per operation. Owns the step counter.
// Ports       : clk, rst_n      - clock, async active-low reset
//               start           - load operands and begin (one cycle pulse)
//               op[1:0]         - 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//               a, b            - operands (sampled on start)
//               done            - high in the cycle whose edge completes the op
//               result          - final value, valid while done is high
// Revision    : 1.0 - initial release
//==============================================================================
module alu_muldiv #(
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    output logic                done,
    output logic [WORDSIZE-1:0] result
);

    localparam int CW = $clog2(WORDSIZE) + 1;
    localparam logic [CW-1:0] c_count_init = CW'(WORDSIZE);
    localparam logic [CW-1:0] c_count_last = CW'(1);

    // Shared datapath registers:
    //   multiply: {r_hi, r_lo} is the running product, r_lo starts as the
    //             multiplier B, r_opnd holds the multiplicand A.
    //   divide:   r_hi is the partial remainder, r_lo shifts the dividend A
    //             out and the quotient bits in, r_opnd holds the divisor B.
    logic [CW-1:0]       r_cnt;
    logic [1:0]          r_op;
    logic [WORDSIZE-1:0] r_hi;
    logic [WORDSIZE-1:0] r_lo;
    logic [WORDSIZE-1:0] r_opnd;

    logic [WORDSIZE:0]   w_sum;
    logic [WORDSIZE:0]   w_shift;
    logic [WORDSIZE:0]   w_diff;
    logic                w_ge;
    logic [WORDSIZE-1:0] w_hi_nxt;
    logic [WORDSIZE-1:0] w_lo_nxt;

    always_comb begin
        w_sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WORDSIZE{1'b0}})};
        w_shift  = {r_hi, r_lo[WORDSIZE-1]};
        w_diff   = w_shift - {1'b0, r_opnd};
        // No borrow means the shifted remainder is >= divisor. A zero
        // divisor never borrows, which yields an all-ones quotient and a
        // remainder equal to the dividend without any special casing.
        w_ge     = ~w_diff[WORDSIZE];
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_op[1]) begin
            w_hi_nxt = w_ge ? w_diff[WORDSIZE-1:0] : w_shift[WORDSIZE-1:0];
            w_lo_nxt = {r_lo[WORDSIZE-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[WORDSIZE:1];
            w_lo_nxt = {w_sum[0], r_lo[WORDSIZE-1:1]};
        end
    end

    // The result is taken from the post-step values so the caller can
    // register it on the same edge that performs the final step.
    assign done   = (r_cnt == c_count_last);
    assign result = r_op[0] ? w_hi_nxt : w_lo_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
        end else if (start) begin
            r_cnt  <= c_count_init;
            r_op   <= op;
            r_hi   <= '0;
            r_lo   <= op[1] ? a : b;
            r_opnd <= op[1] ? b : a;
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - c_count_last;
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
//==============================================================================
// Module      : alu_seq
// Description : Handshaked sequential ALU. Simple ops complete on the accept
//               edge; MUL/MULHU/DIVU/REMU run on the iterative engine for
//               WORDSIZE cycles. The result is held until consumed.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid / in_ready  - operand handshake (a, b, ctl)
//               a, b                 - operands (shift amount in b's low bits)
//               ctl[3:0]             - operation select
//               out_valid/out_ready  - result handshake
//               r                    - registered result
//               z                    - registered zero flag of r
// Revision    : 1.0 - initial release
//==============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    input  logic [3:0]          ctl,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] r,
    output logic                z
);

    localparam int SW = $clog2(WORDSIZE);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORDSIZE-1:0] r_res;
    logic                r_zero;

    logic                w_accept;
    logic                w_iter;
    logic                w_md_start;
    logic                w_md_done;
    logic [WORDSIZE-1:0] w_md_result;
    logic [WORDSIZE-1:0] w_simple;
    logic [SW-1:0]       w_shamt;

    assign w_iter     = is_iterative(ctl);
    assign w_accept   = in_valid & in_ready;
    assign w_md_start = w_accept & w_iter;
    assign w_shamt    = b[SW-1:0];

    // Single-cycle datapath. Iterative and unused codes give zero here; the
    // iterative ones never load from this path.
    always_comb begin
        w_simple = '0;
        case (ctl)
            c_ctl_and: w_simple = a & b;
            c_ctl_or:  w_simple = a | b;
            c_ctl_add: w_simple = a + b;
            c_ctl_sub: w_simple = a - b;
            c_ctl_xor: w_simple = a ^ b;
            c_ctl_nor: w_simple = ~(a | b);
            c_ctl_slt: w_simple = {{(WORDSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            c_ctl_sll: w_simple = a << w_shamt;
            c_ctl_srl: w_simple = a >> w_shamt;
            c_ctl_sra: w_simple = $unsigned($signed(a) >>> w_shamt);
            c_ctl_mul, c_ctl_mulhu, c_ctl_divu, c_ctl_remu: w_simple = '0;
            default:   w_simple = '0;
        endcase
    end

    alu_muldiv #(
        .WORDSIZE (WORDSIZE)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_md_start),
        .op     (ctl[1:0]),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .result (w_md_result)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and ready. in_ready depends only on state and out_ready so
    // upstream can compute its valid without a combinational loop.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_iter ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_md_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_nxt = w_iter ? ST_BUSY : ST_DONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result register. Z is always computed from the value being loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res  <= '0;
            r_zero <= 1'b1;
        end else if (w_accept && !w_iter) begin
            r_res  <= w_simple;
            r_zero <= (w_simple == '0);
        end else if ((r_state == ST_BUSY) && w_md_done) begin
            r_res  <= w_md_result;
            r_zero <= (w_md_result == '0);
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign r         = r_res;
    assign z         = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq at WORDSIZE = 4. A
//               transaction-level model predicts out_valid / in_ready / r / z
//               every cycle; directed vectors pin hand-computed results.
// Ports       : none
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_seq;

    localparam int W = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [3:0]   ctl       = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] r;
    logic         z;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(
        .WORDSIZE (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ctl       (ctl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .z         (z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Arithmetic definition of each operation on 4-bit values.
    function automatic int model(input int c, input int x, input int y);
        int sh;
        int sx;
        int sy;
        sh = y % 4;
        sx = (x >= 8) ? x - 16 : x;
        sy = (y >= 8) ? y - 16 : y;
        case (c)
            0:  return x & y;
            1:  return x | y;
            2:  return (x + y) % 16;
            3:  return x ^ y;
            4:  return (x << sh) % 16;
            5:  return x >> sh;
            6:  return (x - y + 16) % 16;
            7:  return (sx < sy) ? 1 : 0;
            8:  return (x * y) % 16;
            9:  return (x * y) / 16;
            10: return (y == 0) ? 15 : x / y;
            11: return (y == 0) ? x : x % y;
            12: return 15 - (x | y);
            13: return (sx >>> sh) & 15;
            default: return 0;
        endcase
    endfunction

    // Transaction model: held result, valid flag, remaining busy cycles.
    int m_valid = 0;
    int m_r     = 0;
    int m_busy  = 0;
    int m_pend  = 0;
    int m_ready;
    int m_res;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 0;
            m_r     = 0;
            m_busy  = 0;
            m_pend  = 0;
        end
        m_ready = ((m_busy == 0) && (m_valid == 0 || out_ready)) ? 1 : 0;
        chk("cyc_out_valid", int'(out_valid), m_valid);
        chk("cyc_in_ready", int'(in_ready), m_ready);
        chk("cyc_r", int'(r), m_r);
        chk("cyc_z", int'(z), (m_r == 0) ? 1 : 0);
        if (rst_n) begin
            if (in_valid && m_ready != 0) begin
                m_res = model(int'(ctl), int'(a), int'(b));
                if (ctl >= 4'd8 && ctl <= 4'd11) begin
                    m_valid = 0;
                    m_busy  = W;
                    m_pend  = m_res;
                end else begin
                    m_valid = 1;
                    m_r     = m_res;
                end
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1;
                    m_r     = m_pend;
                end
            end else if (m_valid != 0 && out_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [3:0] x, input logic [3:0] y);
        ctl      = c;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_simple(input string name, input logic [3:0] c,
                                 input logic [3:0] x, input logic [3:0] y, input int exp_r);
        issue(c, x, y);
        chk(name, int'(r), exp_r);
        chk({name, "_z"}, int'(z), (exp_r == 0) ? 1 : 0);
        chk({name, "_ov"}, int'(out_valid), 1);
        chk({name, "_rdy"}, int'(in_ready), int'(out_ready));
    endtask

    // Accept edge counts as the first latency edge; operands are scrambled
    // while busy to show they were captured at accept.
    task automatic expect_iter(input string name, input logic [3:0] c,
                               input logic [3:0] x, input logic [3:0] y, input int exp_r);
        int edges;
        int low;
        issue(c, x, y);
        edges = 0;
        low   = 0;
        while (!out_valid && edges < 20) begin
            if (!in_ready) low++;
            a   = 4'($urandom);
            b   = 4'($urandom);
            ctl = 4'($urandom);
            step();
            edges++;
        end
        chk(name, int'(r), exp_r);
        chk({name, "_lat"}, edges + 1, W + 1);
        chk({name, "_stall"}, low, W);
    endtask

    initial begin
        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_z", int'(z), 1);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        step();

        // back-to-back simple ops
        expect_simple("and_7_5", 4'b0000, 4'd7, 4'd5, 5);
        expect_simple("or_1_4", 4'b0001, 4'd1, 4'd4, 5);
        expect_simple("add_3_2", 4'b0010, 4'd3, 4'd2, 5);
        expect_simple("sub_5_5", 4'b0110, 4'd5, 4'd5, 0);
        expect_simple("add_15_3", 4'b0010, 4'd15, 4'd3, 2);
        expect_simple("slt_8_1", 4'b0111, 4'd8, 4'd1, 1);
        expect_simple("sra_8_1", 4'b1101, 4'd8, 4'd1, 12);
        expect_simple("sll_3_3", 4'b0100, 4'd3, 4'd3, 8);
        expect_simple("srl_12_2", 4'b0101, 4'd12, 4'd2, 3);
        expect_simple("xor_12_10", 4'b0011, 4'd12, 4'd10, 6);
        expect_simple("nor_5_2", 4'b1100, 4'd5, 4'd2, 8);
        expect_simple("unused_1110", 4'b1110, 4'd9, 4'd9, 0);

        // iterative ops, each accepted directly out of DONE
        expect_iter("mul_3_6", 4'b1000, 4'd3, 4'd6, 2);
        expect_iter("mulhu_3_6", 4'b1001, 4'd3, 4'd6, 1);
        expect_iter("divu_13_4", 4'b1010, 4'd13, 4'd4, 3);
        expect_iter("remu_13_4", 4'b1011, 4'd13, 4'd4, 1);
        expect_iter("divu_9_0", 4'b1010, 4'd9, 4'd0, 15);
        expect_iter("remu_9_0", 4'b1011, 4'd9, 4'd0, 9);
        expect_iter("mulhu_15_15", 4'b1001, 4'd15, 4'd15, 14);
        step();

        // backpressure
        out_ready = 1'b0;
        expect_simple("bp_add_2_5", 4'b0010, 4'd2, 4'd5, 7);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_r", int'(r), 7);
            chk("bp_hold_rdy", int'(in_ready), 0);
            chk("bp_hold_ov", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        expect_simple("bp_or_3_6", 4'b0001, 4'd3, 4'd6, 7);
        step();

        // reset two cycles into a multiply
        issue(4'b1000, 4'd3, 4'd6);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_r", int'(r), 0);
        chk("abort_z", int'(z), 1);
        chk("abort_in_ready", int'(in_ready), 1);
        step();
        step();
        rst_n = 1'b1;
        expect_simple("post_rst_add_1_1", 4'b0010, 4'd1, 4'd1, 2);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
